// File: rtl/block_map_wr_arbiter_pkg.sv
// Shared constants and types for the block map write-port arbiter.
// The level-init sweep is compiled in only when BLOCK_MAP_INIT_EN is defined.
package block_map_wr_arbiter_pkg;

  localparam int MAP_W      = 33;
  localparam int MAP_H      = 27;
  localparam int MAP_CELLS  = MAP_W * MAP_H;
  localparam int ADDR_W     = 10;
  localparam int SPAWN_SIZE = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    SERVE = 2'd2
  } state_t;

endpackage

// File: rtl/block_map_wr_arbiter_fifo.sv
// Explosion clear request FIFO: power-of-two depth, flush input, and
// full/empty derived from registered pointers.
module blk_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_push = push && !full && !flush;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/block_map_wr_arbiter.sv
// Write-port arbiter for the arena block map RAM: init sweep, explosion FIFO
// and auxiliary writer. Sweep present only with BLOCK_MAP_INIT_EN defined.
module block_map_wr_arbiter #(
  parameter int MAP_W      = block_map_wr_arbiter_pkg::MAP_W,
  parameter int MAP_H      = block_map_wr_arbiter_pkg::MAP_H,
  parameter int ADDR_W     = block_map_wr_arbiter_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pause,
  input  logic              init_req,
  output logic              init_busy,
  input  logic              exp_valid,
  input  logic [ADDR_W-1:0] exp_addr,
  output logic              exp_ready,
  input  logic              aux_valid,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic              aux_data,
  output logic              aux_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_din,
  output logic              err_oob
);

  import block_map_wr_arbiter_pkg::*;

  localparam int                CELLS     = MAP_W * MAP_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  state_t            state;
  logic              last_grant_aux;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] fifo_head;
  logic              exp_push;
  logic              can_grant;
  logic              grant_exp;
  logic              grant_aux;
  logic [ADDR_W-1:0] grant_addr;
  logic              grant_din;
  logic              grant_oob;

`ifdef BLOCK_MAP_INIT_EN
  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);

  logic [ADDR_W-1:0] sw_addr;
  logic [XW-1:0]     sw_x;
  logic [YW-1:0]     sw_y;
  logic              sweep_din;

  // Pillars on odd/odd tiles and a cleared spawn corner; everything else solid.
  always_comb begin
    sweep_din = !((sw_x[0] & sw_y[0]) |
                  ((sw_x < XW'(SPAWN_SIZE)) & (sw_y < YW'(SPAWN_SIZE))));
  end
`else
  assign init_busy = 1'b0;
`endif

  blk_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (init_req),
    .push      (exp_push),
    .push_data (exp_addr),
    .pop       (grant_exp),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Round-robin only matters on contention; a lone pending source always wins.
  always_comb begin
    exp_ready  = !fifo_full && (state != INIT);
    exp_push   = exp_valid && exp_ready;
    can_grant  = !pause && !init_req && (state != INIT);
    grant_exp  = can_grant && !fifo_empty && (!aux_valid || last_grant_aux);
    grant_aux  = can_grant && aux_valid && (fifo_empty || !last_grant_aux);
    aux_ready  = grant_aux;
    grant_addr = grant_aux ? aux_addr : fifo_head;
    grant_din  = grant_aux ? aux_data : 1'b0;
    grant_oob  = (grant_addr > LAST_ADDR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_grant_aux <= 1'b1;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_din        <= 1'b0;
      err_oob        <= 1'b0;
`ifdef BLOCK_MAP_INIT_EN
      init_busy      <= 1'b0;
      sw_addr        <= '0;
      sw_x           <= '0;
      sw_y           <= '0;
`endif
    end else begin
      ram_we  <= 1'b0;
      err_oob <= 1'b0;
`ifdef BLOCK_MAP_INIT_EN
      // Held one cycle past the sweep so it covers the final write on the bus.
      init_busy <= init_req || (state == INIT);
`endif
      if (init_req) begin
`ifdef BLOCK_MAP_INIT_EN
        state   <= INIT;
        sw_addr <= '0;
        sw_x    <= '0;
        sw_y    <= '0;
`else
        state   <= IDLE;
`endif
      end
`ifdef BLOCK_MAP_INIT_EN
      else if (state == INIT) begin
        if (!pause) begin
          ram_we   <= 1'b1;
          ram_addr <= sw_addr;
          ram_din  <= sweep_din;
          if (sw_addr == LAST_ADDR) begin
            state <= IDLE;
          end else begin
            sw_addr <= sw_addr + ADDR_W'(1);
            if (sw_x == XW'(MAP_W - 1)) begin
              sw_x <= '0;
              sw_y <= sw_y + YW'(1);
            end else begin
              sw_x <= sw_x + XW'(1);
            end
          end
        end
      end
`endif
      else begin
        if (grant_exp || grant_aux) begin
          last_grant_aux <= grant_aux;
          if (grant_oob) begin
            err_oob <= 1'b1;
          end else begin
            ram_we   <= 1'b1;
            ram_addr <= grant_addr;
            ram_din  <= grant_din;
          end
        end
        state <= (!fifo_empty || aux_valid) ? SERVE : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_block_map_wr_arbiter.sv
// Table-driven bench for block_map_wr_arbiter plus directed multi-cycle sequences;
// sweep sequences run only when BLOCK_MAP_INIT_EN is defined.
module tb_block_map_wr_arbiter;

  logic       clk;
  logic       reset_n;
  logic       pause;
  logic       init_req;
  logic       init_busy;
  logic       exp_valid;
  logic [9:0] exp_addr;
  logic       exp_ready;
  logic       aux_valid;
  logic [9:0] aux_addr;
  logic       aux_data;
  logic       aux_ready;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_din;
  logic       err_oob;

  int n_applied;
  int n_miscompares;

  block_map_wr_arbiter #(
    .MAP_W      (33),
    .MAP_H      (27),
    .ADDR_W     (10),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pause     (pause),
    .init_req  (init_req),
    .init_busy (init_busy),
    .exp_valid (exp_valid),
    .exp_addr  (exp_addr),
    .exp_ready (exp_ready),
    .aux_valid (aux_valid),
    .aux_addr  (aux_addr),
    .aux_data  (aux_data),
    .aux_ready (aux_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .err_oob   (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pause;
    logic       ev;
    logic [9:0] ea;
    logic       av;
    logic [9:0] aa;
    logic       ad;
    logic       x_exp_ready;
    logic       x_aux_ready;
    logic       x_we;
    logic [9:0] x_addr;
    logic       x_din;
    logic       x_oob;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pause     = 1'b0;
    init_req  = 1'b0;
    exp_valid = 1'b0;
    exp_addr  = '0;
    aux_valid = 1'b0;
    aux_addr  = '0;
    aux_data  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " init_busy"}, 32'(init_busy), 0);
    check({tag, " exp_ready"}, 32'(exp_ready), 1);
    check({tag, " aux_ready"}, 32'(aux_ready), 0);
    check({tag, " ram_we"},    32'(ram_we),    0);
    check({tag, " ram_addr"},  32'(ram_addr),  0);
    check({tag, " ram_din"},   32'(ram_din),   0);
    check({tag, " err_oob"},   32'(err_oob),   0);
  endtask

  task automatic check_write(input string tag, input int addr, input int din);
    check({tag, " we"},   32'(ram_we),   1);
    check({tag, " addr"}, 32'(ram_addr), 32'(addr));
    check({tag, " din"},  32'(ram_din),  32'(din));
  endtask

  function automatic int tile_din(input int i);
    int x;
    int y;
    x = i % 33;
    y = i / 33;
    if ((x % 2 == 1) && (y % 2 == 1)) return 0;
    if (x < 2 && y < 2) return 0;
    return 1;
  endfunction

  initial begin
    n_applied     = 0;
    n_miscompares = 0;
    idle_inputs();
    reset_n = 1'b0;

    //                pause ev ea   av aa   ad  xer xar xwe xaddr xdin xoob
    vecs[0]  = '{1'b0, 1'b0, 10'd0,   1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 10'd0,   1'b1, 10'd5,   1'b1, 1'b1, 1'b1, 1'b1, 10'd5,   1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 10'd100, 1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 10'd101, 1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 1'b1, 10'd100, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 10'd0,   1'b1, 10'd300, 1'b1, 1'b1, 1'b1, 1'b1, 10'd300, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 10'd0,   1'b1, 10'd301, 1'b0, 1'b1, 1'b0, 1'b1, 10'd101, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 10'd0,   1'b1, 10'd301, 1'b0, 1'b1, 1'b1, 1'b1, 10'd301, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 10'd0,   1'b1, 10'd302, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 10'd102, 1'b1, 10'd302, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 10'd0,   1'b1, 10'd302, 1'b1, 1'b1, 1'b0, 1'b1, 10'd102, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 10'd0,   1'b1, 10'd302, 1'b1, 1'b1, 1'b1, 1'b1, 10'd302, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 10'd0,   1'b1, 10'd891, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0,   1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 10'd0,   1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 10'd891, 1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 10'd0,   1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 10'd0,   1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 10'd0,   1'b1, 10'd890, 1'b0, 1'b1, 1'b1, 1'b1, 10'd890, 1'b0, 1'b0};

    #12;
    check_reset_values("reset");
    step();
    reset_n = 1'b1;
    step();

    // Single-cycle arbitration vectors
    for (int i = 0; i < 17; i++) begin
      pause     = vecs[i].pause;
      exp_valid = vecs[i].ev;
      exp_addr  = vecs[i].ea;
      aux_valid = vecs[i].av;
      aux_addr  = vecs[i].aa;
      aux_data  = vecs[i].ad;
      #1;
      check($sformatf("v%0d exp_ready", i), 32'(exp_ready), 32'(vecs[i].x_exp_ready));
      check($sformatf("v%0d aux_ready", i), 32'(aux_ready), 32'(vecs[i].x_aux_ready));
      step();
      check($sformatf("v%0d ram_we", i),  32'(ram_we),  32'(vecs[i].x_we));
      check($sformatf("v%0d err_oob", i), 32'(err_oob), 32'(vecs[i].x_oob));
      if (vecs[i].x_we) begin
        check($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].x_addr));
        check($sformatf("v%0d ram_din", i),  32'(ram_din),  32'(vecs[i].x_din));
      end
    end
    idle_inputs();
    step();

    // FIFO fill while paused, then drain with a refused push against a full FIFO
    pause     = 1'b1;
    exp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = 10'(100 + i);
      step();
    end
    check("fill exp_ready full", 32'(exp_ready), 0);
    pause    = 1'b0;
    exp_addr = 10'd104;
    #1;
    check("fill aux_ready", 32'(aux_ready), 0);
    step();
    check_write("drain 100", 100, 0);
    check("drain exp_ready freed", 32'(exp_ready), 1);
    step();
    exp_valid = 1'b0;
    check_write("drain 101", 101, 0);
    for (int i = 2; i < 5; i++) begin
      step();
      check_write($sformatf("drain %0d", 100 + i), 100 + i, 0);
    end
    step();
    check("drain done we", 32'(ram_we), 0);

    // Contention: writes alternate, aux first because the FIFO starts empty
    exp_valid = 1'b1;
    exp_addr  = 10'd200;
    aux_valid = 1'b1;
    aux_addr  = 10'd300;
    aux_data  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k % 2 == 0) check_write($sformatf("rr k%0d", k), 300, 1);
      else            check_write($sformatf("rr k%0d", k), 200, 0);
    end
    idle_inputs();
    for (int k = 0; k < 6; k++) step();
    check("rr drained we", 32'(ram_we), 0);
    check("rr drained exp_ready", 32'(exp_ready), 1);

`ifdef BLOCK_MAP_INIT_EN
    begin
      int bad;
      // Two queued requests, then init_req while paused: FIFO flushed, sweep starts
      pause     = 1'b1;
      exp_valid = 1'b1;
      exp_addr  = 10'd400;
      step();
      exp_addr  = 10'd401;
      step();
      exp_valid = 1'b0;
      init_req  = 1'b1;
      step();
      init_req  = 1'b0;
      pause     = 1'b0;
      check("init busy rise", 32'(init_busy), 1);
      check("init req cycle we", 32'(ram_we), 0);
      #1;
      check("init exp_ready", 32'(exp_ready), 0);
      bad = 0;
      for (int i = 0; i < 891; i++) begin
        step();
        if (i == 0 || i == 2 || i == 34 || i == 501 || i == 890) begin
          check_write($sformatf("sweep %0d", i), i, tile_din(i));
        end else if (ram_we !== 1'b1 || int'(ram_addr) != i || int'(ram_din) != tile_din(i)) begin
          if (bad == 0) $display("FAIL sweep first bad index %0d: got we=%0d addr=%0d din=%0d, expected addr=%0d din=%0d",
                                 i, ram_we, ram_addr, ram_din, i, tile_din(i));
          bad++;
        end
        if (i == 500) begin
          pause = 1'b1;
          for (int p = 0; p < 10; p++) begin
            step();
            if (ram_we !== 1'b0) bad++;
          end
          check("pause busy held", 32'(init_busy), 1);
          pause = 1'b0;
        end
      end
      check("sweep bad count", 32'(bad), 0);
      check("sweep busy at last", 32'(init_busy), 1);
      step();
      check("sweep busy fall", 32'(init_busy), 0);
      check("sweep end we", 32'(ram_we), 0);
      step();
      step();
      check("flushed fifo no write", 32'(ram_we), 0);

      // Restart during INIT: no write in the restart cycle, resumes at 0
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        check_write($sformatf("pre-restart %0d", i), i, tile_din(i));
      end
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      check("restart cycle we", 32'(ram_we), 0);
      step();
      check_write("restart 0", 0, 0);
      step();
      check_write("restart 1", 1, 0);
      for (int i = 0; i < 20; i++) step();

      // Reset mid-sweep aborts immediately
      reset_n = 1'b0;
      #1;
      check_reset_values("sweep reset");
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        check($sformatf("post sweep reset we %0d", i), 32'(ram_we), 0);
        check($sformatf("post sweep reset busy %0d", i), 32'(init_busy), 0);
      end
    end
`else
    // init_req only flushes the FIFO in this build
    pause     = 1'b1;
    exp_valid = 1'b1;
    exp_addr  = 10'd400;
    step();
    exp_addr  = 10'd401;
    step();
    exp_valid = 1'b0;
    init_req  = 1'b1;
    step();
    init_req  = 1'b0;
    pause     = 1'b0;
    check("flush busy", 32'(init_busy), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("flush no write %0d", i), 32'(ram_we), 0);
    end
    check("flush exp_ready", 32'(exp_ready), 1);
`endif

    // Reset with two queued requests: contents lost, back to IDLE
    pause     = 1'b1;
    exp_valid = 1'b1;
    exp_addr  = 10'd600;
    step();
    exp_addr  = 10'd601;
    step();
    exp_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_reset_values("fifo reset");
    step();
    reset_n = 1'b1;
    pause   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post fifo reset we %0d", i), 32'(ram_we), 0);
    end
    aux_valid = 1'b1;
    aux_addr  = 10'd7;
    aux_data  = 1'b1;
    #1;
    check("post reset aux_ready", 32'(aux_ready), 1);
    step();
    aux_valid = 1'b0;
    check_write("post reset aux", 7, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule

// File: doc/block_map_wr_arbiter.md
# block_map_wr_arbiter

Arbiter and sequencer for the single write port of the arena block map RAM (33 × 27 tiles, 891 entries). It shares that port among three sources: a level-initialisation sweep, explosion clear requests from the bomb logic, and a generic auxiliary writer (power-up and level-editor writes). It sits between those requesters and the block map RAM. It replaces the direct write-enable/address connection from the bomb logic.

## Interface
Parameters:
- MAP_W, 33, tiles per arena row
- MAP_H, 27, tile rows
- ADDR_W, 10, RAM address width
- FIFO_DEPTH, 4, explosion request FIFO entries (power of two, ≥ 2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- pause  in  1  freezes grants and the init sweep
- init_req  in  1  single-cycle pulse: start/restart the level init sweep
- init_busy  out  1  high while the sweep is writing
- exp_valid  in  1  explosion clear request
- exp_addr  in  ADDR_W  tile to clear (data 0)
- exp_ready  out  1  FIFO not full
- aux_valid  in  1  auxiliary write request
- aux_addr  in  ADDR_W  auxiliary address
- aux_data  in  1  auxiliary data bit
- aux_ready  out  1  auxiliary request granted this cycle
- ram_we  out  1  block map write enable
- ram_addr  out  ADDR_W  block map write address
- ram_din  out  1  block map write data
- err_oob  out  1  one-cycle pulse: a request with address ≥ MAP_W*MAP_H was dropped

## Operation
- FSM states:
  - IDLE
  - INIT
  - SERVE
- Transitions:
  - Reset → IDLE.
  - init_req from any state → INIT: address and column counters zeroed, FIFO flushed.
  - INIT → IDLE after writing address 890.
  - IDLE ↔ SERVE whenever any source is pending.
- INIT sweep writes one address per unpaused cycle, 0..MAP_W*MAP_H-1, ascending. Column counter x wraps at MAP_W, and the row counter y increments on the wrap (no multiplier). Data for each tile:
  - 0 if x odd and y odd (pillar cells)
  - 0 if x<2 and y<2 (spawn corner)
  - 1 otherwise
- During INIT:
  - exp_ready = 0
  - aux_ready = 0
- Explosion path:
  - Push on exp_valid & exp_ready.
  - exp_ready is the registered !full.
  - Push and pop in the same cycle are allowed, including when the FIFO is full (the pop frees the slot next cycle; the push is still refused that cycle).
- Grant in SERVE: round-robin between FIFO head and aux, toggled by a last_grant bit. The single pending source always wins. aux_ready is asserted combinationally in the cycle aux wins.
- pause:
  - No grant.
  - No sweep advance.
  - ram_we = 0.
  - FIFO still accepts pushes while not full.
  - init_req is still honoured.
- Out-of-range address (≥891): the request is consumed (popped, or aux_ready given) but no write is issued. err_oob pulses one cycle, aligned with where ram_we would have been.

## Timing
- Reset values:
  - init_busy = 0
  - exp_ready = 1
  - aux_ready = 0
  - ram_we = 0
  - ram_addr = 0
  - ram_din = 0
  - err_oob = 0
- ram_we, ram_addr and ram_din are registered. A grant or sweep step in cycle N produces the write in cycle N+1. Throughput is one write per cycle.
- init_busy:
  - rises in the cycle after init_req
  - falls in the cycle after the final write (address 890) is presented
  - a full unpaused sweep takes 891 write cycles
- An explosion request pushed in cycle N, into an empty FIFO with no contention, appears on ram_we in cycle N+2.
- init_req during INIT restarts at address 0. No write to an address is duplicated in the restart cycle.
- Asserting reset_n low mid-operation aborts immediately: outputs take their reset values, and FIFO contents are lost.

## Configuration
- BLOCK_MAP_INIT_EN:
  - Defined: INIT state, sweep counters and the pattern generator are compiled in.
  - Undefined: init_req is ignored except for flushing the FIFO, init_busy is tied 0, the FSM is IDLE/SERVE only, and the RAM keeps its preloaded contents.

## Structure
- Shared package holds:
  - MAP_W, MAP_H, MAP_CELLS (=891), ADDR_W
  - state enum {IDLE, INIT, SERVE}
  - the spawn-corner size
- One sub-module is natural: blk_req_fifo (synchronous FIFO, push/pop/full/empty, flush input). The arbiter, FSM and sweep stay in the top module.

## Test plan
- Reset, then init_req → 891 consecutive writes with no pause:
  - addr 0 din 0
  - addr 34 (x=1, y=1) din 0
  - addr 2 din 1
  - addr 890 din 1
  - init_busy low 1 cycle after the last write
- FIFO fill and drain:
  - Push 4 exp requests (addrs 100..103) in 4 cycles with aux idle → exp_ready low after the 4th.
  - Writes appear at 100, 101, 102, 103 with din 0, in order.
- Contention: exp pending 200, aux pending 300/data 1 continuously → writes alternate 200/300 every cycle.
- Pause 10 cycles mid-sweep at addr 500 → no ram_we during the pause; resumes at 501 with no address skipped or repeated.
- exp_addr 891 → err_oob pulses once, no ram_we, FIFO is empty afterwards.
- init_req while the FIFO holds 2 entries, and reset_n asserted mid-sweep → FIFO flushed; after reset all outputs return to their reset values and the state is IDLE.
